// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator: scans operands MSB-first and stops
// at the first differing bit, reporting A>B, A==B or A<B with a one-cycle done pulse.
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             e,
    output logic             l
);

    // One counter bit minimum so WIDTH=1 still has a legal (always-zero) counter.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;

    logic x;
    logic y;
    logic bit_gt;
    logic bit_lt;
    logic bit_eq;

    assign x      = sh_a[WIDTH-1];
    assign y      = sh_b[WIDTH-1];
    assign bit_gt = x & ~y;
    assign bit_lt = ~x & y;
    assign bit_eq = ~(x ^ y);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            g     <= 1'b0;
            e     <= 1'b0;
            l     <= 1'b0;
            cnt   <= '0;
            sh_a  <= '0;
            sh_b  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        cnt   <= CNT_LOAD;
                        g     <= 1'b0;
                        e     <= 1'b0;
                        l     <= 1'b0;
                        busy  <= 1'b1;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    // First differing bit decides the result; start is ignored here.
                    if (bit_gt) begin
                        g     <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (bit_lt) begin
                        l     <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (bit_eq && cnt == '0) begin
                        e     <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        sh_a <= sh_a << 1;
                        sh_b <= sh_b << 1;
                        cnt  <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Randomized and directed checks of serial_mag_comparator at WIDTH=8 and WIDTH=1
// against an arithmetic reference model of result and latency.
module tb_serial_mag_comparator;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8, done8, g8, e8, l8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       busy1, done1, g1, e1, l1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_mag_comparator #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .g(g8), .e(e8), .l(l8)
    );

    serial_mag_comparator #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .g(g1), .e(e1), .l(l1)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Outputs packed as {busy,done,g,e,l}.
    function automatic logic [7:0] obs8();
        return {3'b000, busy8, done8, g8, e8, l8};
    endfunction

    function automatic logic [7:0] obs1();
        return {3'b000, busy1, done1, g1, e1, l1};
    endfunction

    // Reference: {g,e,l} from plain unsigned comparison.
    function automatic logic [2:0] ref_res(input int unsigned av, input int unsigned bv);
        if (av > bv) return 3'b100;
        if (av == bv) return 3'b010;
        return 3'b001;
    endfunction

    // Busy cycles: WIDTH for equal operands, else one more than the count of equal leading bits.
    function automatic int ref_lat(input int unsigned av, input int unsigned bv, input int w);
        int unsigned d;
        int msb;
        d = av ^ bv;
        if (d == 0) return w;
        msb = $clog2(d + 1) - 1;
        return w - msb;
    endfunction

    // Called at a negedge; start is sampled at the end of this cycle (T).
    // Returns at the negedge of the done cycle with start low.
    task automatic cmp8(input logic [7:0] av, input logic [7:0] bv, input string tag);
        int lat;
        logic [2:0] res;
        lat = ref_lat(av, bv, 8);
        res = ref_res(av, bv);
        start8 = 1'b1;
        a8 = av;
        b8 = bv;
        @(negedge clk);
        for (int n = 1; n <= lat; n++) begin
            check({tag, "_busy"}, obs8(), 8'b000_1_0_000);
            start8 = (n == 3) ? 1'b1 : 1'($urandom_range(0, 1));
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            @(negedge clk);
        end
        start8 = 1'b0;
        check({tag, "_done"}, obs8(), {3'b000, 2'b01, res});
    endtask

    task automatic cmp1(input logic av, input logic bv, input string tag);
        logic [2:0] res;
        res = ref_res(32'(av), 32'(bv));
        start1 = 1'b1;
        a1 = av;
        b1 = bv;
        @(negedge clk);
        check({tag, "_busy"}, obs1(), 8'b000_1_0_000);
        start1 = 1'b1;
        a1 = ~av;
        b1 = bv;
        @(negedge clk);
        start1 = 1'b0;
        check({tag, "_done"}, obs1(), {3'b000, 2'b01, res});
    endtask

    initial begin
        logic [2:0] last;
        logic [7:0] ra, rb;

        // Reset state, with start asserted to show reset wins.
        start8 = 1'b1;
        a8 = 8'h12;
        start1 = 1'b1;
        repeat (3) @(negedge clk);
        check("reset8", obs8(), 8'h00);
        check("reset1", obs1(), 8'h00);
        start8 = 1'b0;
        start1 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle8", obs8(), 8'h00);

        // Early termination on the MSB.
        cmp8(8'h80, 8'h7F, "msb_gt");
        @(negedge clk);
        check("hold_gt", obs8(), 8'b000_0_0_100);

        cmp8(8'hA5, 8'hA5, "equal");
        @(negedge clk);
        check("hold_eq", obs8(), 8'b000_0_0_010);

        // Ignored re-start at T+3, then start accepted in the done cycle.
        cmp8(8'h05, 8'h06, "lsb_lt");
        cmp8(8'hFF, 8'h00, "restart_in_done");
        repeat (2) @(negedge clk);
        check("hold_gt2", obs8(), 8'b000_0_0_100);

        // Reset during an equal-operand compare: no done pulse afterwards.
        start8 = 1'b1;
        a8 = 8'h3C;
        b8 = 8'h3C;
        @(negedge clk);
        start8 = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            check("pre_abort_busy", obs8(), 8'b000_1_0_000);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            check("post_abort", obs8(), 8'h00);
            @(negedge clk);
        end

        // First start after reset behaves as after power-up.
        cmp8(8'h3C, 8'h3D, "after_rst");

        // Randomized operands, biased toward long common prefixes.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            case ($urandom_range(0, 2))
                0: rb = ra;
                1: rb = ra ^ (8'h01 << $urandom_range(0, 7));
                default: rb = 8'($urandom);
            endcase
            cmp8(ra, rb, "rand");
            last = ref_res(32'(ra), 32'(rb));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("rand_hold", obs8(), {3'b000, 2'b00, last});
            end
        end

        // WIDTH=1 truth table.
        @(negedge clk);
        cmp1(1'b0, 1'b0, "w1_00");
        cmp1(1'b0, 1'b1, "w1_01");
        cmp1(1'b1, 1'b0, "w1_10");
        cmp1(1'b1, 1'b1, "w1_11");
        @(negedge clk);
        check("w1_hold", obs1(), 8'b000_0_0_010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
